// File: rtl/sudoku_checker_if.sv
// sudoku_checker_if: request/board/result bundle between a board source and the sudoku checker
interface sudoku_checker_if;
  logic                  start;
  logic [8:0][8:0][3:0]  game_board;
  logic                  busy;
  logic                  done;
  logic                  valid;
  logic                  complete;
  logic [4:0]            first_conflict;
  modport master (output start, game_board, input busy, done, valid, complete, first_conflict);
  modport slave  (input start, game_board, output busy, done, valid, complete, first_conflict);
endinterface

// File: rtl/sudoku_checker.sv
// sudoku_checker: scans a 9x9 board snapshot one cell per clock over rows, columns and boxes
module sudoku_checker #(
  parameter int BOX      = 3,
  parameter int NONE_IDX = 31
) (
  input logic             clock,
  input logic             reset,
  sudoku_checker_if.slave sif
);
  localparam int N = BOX * BOX;
  typedef enum logic {IDLE, SCAN} state_t;
  state_t               state_q, state_d;
  logic [8:0][8:0][3:0] snap_q, snap_d;
  logic [4:0]           g_q, g_d, pend_q, pend_d, fc_q, fc_d;
  logic [3:0]           i_q, i_d;
  logic [8:0]           seen_q, seen_d;
  logic                 err_q, err_d, empty_q, empty_d, done_q, done_d;
  logic                 valid_q, valid_d, complete_q, complete_d;
  logic [4:0]           b;
  logic [1:0]           bq, iq;
  logic [3:0]           row, col, v;
  logic [8:0]           hot;
  logic                 conf, err_n, empty_n, last;
  logic [4:0]           pend_n;
  always_comb begin
    b       = g_q - 5'd18;
    bq      = (b >= 5'd6) ? 2'd2 : (b >= 5'd3) ? 2'd1 : 2'd0;
    iq      = (i_q >= 4'd6) ? 2'd2 : (i_q >= 4'd3) ? 2'd1 : 2'd0;
    row     = (g_q < 5'd9) ? g_q[3:0] : (g_q < 5'd18) ? i_q : 4'(3 * bq + iq);
    col     = (g_q < 5'd9) ? i_q : (g_q < 5'd18) ? 4'(g_q - 5'd9) : 4'(3 * (b - 3 * bq) + (i_q - 3 * iq));
    v       = snap_q[row][col];
    hot     = (v != 4'd0 && v <= 4'd9) ? 9'(1) << (v - 4'd1) : '0;
    conf    = (v > 4'd9) | (|(seen_q & hot));
    err_n   = err_q | conf;
    empty_n = empty_q | (v == 4'd0);
    pend_n  = (conf && !err_q) ? g_q : pend_q;
    last    = (g_q == 5'(3 * N - 1)) && (i_q == 4'(N - 1));
  end
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    g_d        = g_q;
    i_d        = i_q;
    seen_d     = seen_q;
    err_d      = err_q;
    empty_d    = empty_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    complete_d = complete_q;
    fc_d       = fc_q;
    if (state_q == IDLE) begin
      if (sif.start) begin
        state_d = SCAN;
        snap_d  = sif.game_board;
        g_d     = '0;
        i_d     = '0;
        seen_d  = '0;
        err_d   = 1'b0;
        empty_d = 1'b0;
        pend_d  = 5'(NONE_IDX);
      end
    end else begin
      err_d   = err_n;
      empty_d = empty_n;
      pend_d  = pend_n;
      if (last) begin
        state_d    = IDLE;
        done_d     = 1'b1;
        valid_d    = ~err_n;
        complete_d = ~err_n & ~empty_n;
        fc_d       = pend_n;
      end else if (i_q == 4'(N - 1)) begin
        seen_d = '0;
        i_d    = '0;
        g_d    = g_q + 5'd1;
      end else begin
        seen_d = seen_q | hot;
        i_d    = i_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      g_q        <= '0;
      i_q        <= '0;
      seen_q     <= '0;
      err_q      <= 1'b0;
      empty_q    <= 1'b0;
      pend_q     <= 5'(NONE_IDX);
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      complete_q <= 1'b0;
      fc_q       <= 5'(NONE_IDX);
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      g_q        <= g_d;
      i_q        <= i_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      empty_q    <= empty_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
      fc_q       <= fc_d;
    end
  end
  assign sif.busy           = (state_q == SCAN);
  assign sif.done           = done_q;
  assign sif.valid          = valid_q;
  assign sif.complete       = complete_q;
  assign sif.first_conflict = fc_q;
endmodule

// File: doc/sudoku_checker.md
Name: sudoku_checker

Overview:
- Downstream consumer of board_selector's game_board.
- On request, scans a snapshot of the 9x9 board one cell per clock over all 27 groups (9 rows, 9 columns, 9 boxes).
- Reports whether the board has no rule violations and whether it is fully solved.
- Drives the win/error indication logic of the player.

Parameters:
BOX, 3, box edge length; board side N = BOX*BOX (only default 3 is supported/verified)
NONE_IDX, 31, value of first_conflict when no conflict exists

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request a check; sampled only in IDLE
game_board  input  [3:0] x [8:0][8:0]  board from board_selector, indexed [row][col]; 0 = empty, 1-9 = digit
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when results are updated
valid  output  1  no duplicate digit in any group and no illegal value
complete  output  1  valid and no empty cells
first_conflict  output  5  index of first failing group: 0-8 rows, 9-17 cols, 18-26 boxes; NONE_IDX if none

Behaviour:
- Clock and reset: single clock, synchronous active-high reset.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, valid = 0, complete = 0
  - first_conflict = NONE_IDX
  - internal counters, seen mask and flags cleared
- Reset mid-scan aborts the scan immediately. No done pulse is produced and results revert to reset values.
- States: IDLE, SCAN.
- IDLE:
  - start = 1 at edge k captures game_board into an internal snapshot.
  - Clears group counter g (0-26), cell counter i (0-8), the 9-bit seen mask, err flag and empty flag.
  - Sets busy = 1 and goes to SCAN.
  - start is ignored while busy.
- SCAN processes one cell per edge: 243 edges, at k+1 .. k+243.
- Cell address for group g, cell i:
  - row group (g < 9): (g, i)
  - column group (9 <= g < 18): (i, g-9)
  - box group, with b = g-18: row 3*(b/3) + i/3, col 3*(b%3) + i%3
- Per cell value v:
  - v = 0: set empty flag; no mask change.
  - 1 <= v <= 9 and seen[v-1] = 1: conflict.
  - 1 <= v <= 9 and seen[v-1] = 0: set seen[v-1].
  - v >= 10: conflict (illegal value).
  - On conflict, set err. If no conflict has been recorded yet in this scan, latch g into the pending first-conflict register.
- Group rollover: when i = 8, the next edge clears seen and sets i = 0, g = g+1. Otherwise i = i+1.
- Scan end, at the edge processing g = 26, i = 8 (edge k+243):
  - valid = ~err (including this cell)
  - complete = ~err & ~empty
  - first_conflict = pending value, or NONE_IDX if none
  - done = 1, busy = 0, state = IDLE
- done clears at the following edge. A start sampled at that edge (k+244) is accepted.
- Latency: done is high in the cycle after edge k+243, i.e. 243 cycles after start is accepted.
- Result persistence: valid, complete and first_conflict hold their values until the next done or reset. They are not cleared when a new scan starts.
- Snapshot isolation: changes to game_board during SCAN have no effect on the result.
- start held high continuously causes back-to-back scans with no idle gap beyond the done cycle.

Test Plan:
1. Known solved board, pulse start -> busy = 1 for 243 cycles, then done pulse; valid = 1, complete = 1, first_conflict = 31.
2. Board 1 puzzle as loaded by board_selector (cell [0][8] = 2, [1][1] = 6, [2][8] = 8, other givens, remaining cells 0) -> valid = 1, complete = 0, first_conflict = 31.
3. Solved board with [3][4] and [5][4] both 7 (swap) -> valid = 0, complete = 0, first_conflict = 3 (row 3 fails first).
4. Solved board with [2][2] = 12 -> valid = 0, first_conflict = 2.
5. Start scan of a solved board; at cycle 50 overwrite game_board with duplicates and re-pulse start -> single done at cycle 243, valid = 1, complete = 1, no second scan.
6. Reset asserted at cycle 100 of a scan -> busy = 0, done never pulses, valid = 0, first_conflict = 31. A fresh start then yields correct results 243 cycles later.
